// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants, state encoding and count decode for the program loaders
package loader_pkg;

  localparam int         ADDR_W               = 8;
  localparam int         INSTR_W              = 16;
  localparam logic [7:0] SYNC_BYTE            = 8'hA5;
  localparam bit         COUNT_ZERO_MEANS_256 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // A count byte of zero stands for a full 256-word image.
  function automatic logic [ADDR_W:0] decode_count(input logic [7:0] n);
    if (COUNT_ZERO_MEANS_256 && (n == 8'd0)) begin
      return (ADDR_W+1)'(256);
    end
    return (ADDR_W+1)'(n);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - running XOR checksum with clear, accumulate and compare
module loader_checksum
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic [7:0] init_i,
  input  logic       acc_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o,
  output logic       match_o
);

  logic [7:0] sum_q;

  // Clear seeds the sum with the first covered byte; accumulate folds in each later byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'd0;
    end else if (clr_i) begin
      sum_q <= init_i;
    end else if (acc_i) begin
      sum_q <= sum_q ^ byte_i;
    end
  end

  assign sum_o   = sum_q;
  assign match_o = (byte_i == sum_q);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream loader that writes instruction memory and gates the CPU
module imem_loader
  import loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byteIn,
  input  logic               byteValid,
  output logic               byteReady,
  output logic [ADDR_W-1:0]  imemWrAddr,
  output logic [INSTR_W-1:0] imemWrData,
  output logic               imemWrEn,
  output logic               cpuHold,
  output logic               loadDone,
  output logic               loadError,
  output logic [ADDR_W:0]    wordsLoaded
);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [ADDR_W:0]    words_q, words_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [7:0]         hi_q,    hi_d;
  logic [INSTR_W-1:0] data_q,  data_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;
  logic               hold_q,  hold_d;

  logic               xfer;
  logic               cs_clr;
  logic               cs_acc;
  logic               cs_match;
  logic [7:0]         cs_sum;

  assign byteReady = (state_q != ST_WRITE);
  assign xfer      = byteValid && byteReady;

  loader_checksum u_checksum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cs_clr),
    .init_i  (byteIn),
    .acc_i   (cs_acc),
    .byte_i  (byteIn),
    .sum_o   (cs_sum),
    .match_o (cs_match)
  );

  // Frame sequencing: sync, count, hi/lo byte pairs with a write slot after each, checksum.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    cs_clr  = 1'b0;
    cs_acc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer && (byteIn == SYNC_BYTE)) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (xfer) begin
          count_d = decode_count(byteIn);
          cs_clr  = 1'b1;
          addr_d  = '0;
          words_d = '0;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (xfer) begin
          hi_d    = byteIn;
          cs_acc  = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (xfer) begin
          data_d  = {hi_q, byteIn};
          cs_acc  = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q + (ADDR_W+1)'(1);
        state_d = (words_d == count_q) ? ST_CHECK : ST_HI;
      end
      ST_CHECK: begin
        if (xfer) begin
          if (cs_match) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (xfer && (byteIn == SYNC_BYTE)) begin
          state_d = ST_COUNT;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; memory contents are outside and survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      words_q <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign imemWrEn    = (state_q == ST_WRITE);
  assign imemWrAddr  = addr_q;
  assign imemWrData  = data_q;
  assign cpuHold     = hold_q;
  assign loadDone    = done_q;
  assign loadError   = err_q;
  assign wordsLoaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic [7:0]  imemWrAddr;
  logic [15:0] imemWrData;
  logic        imemWrEn;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;
  logic [8:0]  wordsLoaded;

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byteIn      (byteIn),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .imemWrAddr  (imemWrAddr),
    .imemWrData  (imemWrData),
    .imemWrEn    (imemWrEn),
    .cpuHold     (cpuHold),
    .loadDone    (loadDone),
    .loadError   (loadError),
    .wordsLoaded (wordsLoaded)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [7:0]  pay[512];
  bit          gaps = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write monitor: every write strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst_n) begin
      check("rdy_vs_wr", byteReady, !imemWrEn);
      if (imemWrEn) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", imemWrAddr, mon_e[23:16]);
          check("wr_data", imemWrData, mon_e[15:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        byteValid = 1'b0;
      end
    end
    @(negedge clk);
    byteIn    = b;
    byteValid = 1'b1;
    while (!byteReady && n < 10) begin
      @(negedge clk);
      if (gaps) byteValid = $urandom_range(0, 1) == 1;
      n++;
    end
    byteValid = 1'b1;
    if (n >= 10) check("rdy_timeout", n, 0);
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    byteValid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_payload(input int nw);
    for (int i = 0; i < 2 * nw; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input int nw, input bit bad, input bit chk_reload);
    logic [7:0] cs;
    logic [7:0] nb;
    nb = nw[7:0];
    send_byte(8'hA5);
    if (chk_reload) begin
      #1;
      check("reload_hold", cpuHold, 1);
      check("reload_done", loadDone, 0);
      check("reload_err", loadError, 0);
    end
    send_byte(nb);
    cs = nb;
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({i[7:0], pay[2*i], pay[2*i+1]});
      send_byte(pay[2*i]);
      send_byte(pay[2*i+1]);
      cs = cs ^ pay[2*i] ^ pay[2*i+1];
    end
    send_byte(bad ? (cs ^ 8'h01) : cs);
    settle();
    check("q_empty", exp_q.size(), 0);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic hold,
                              input logic [8:0] words);
    check({tag, "_done"}, loadDone, done);
    check({tag, "_err"}, loadError, err);
    check({tag, "_hold"}, cpuHold, hold);
    check({tag, "_words"}, wordsLoaded, words);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    byteIn    = 8'h00;
    byteValid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wren", imemWrEn, 0);
    check("rst_addr", imemWrAddr, 0);
    check("rst_data", imemWrData, 0);
    check("rst_rdy", byteReady, 1);
    check_status("rst", 0, 0, 1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load from the reference stream.
    pay[0] = 8'h4A; pay[1] = 8'h1B; pay[2] = 8'h0C; pay[3] = 8'h33;
    send_frame(2, 0, 0);
    check_status("basic", 1, 0, 0, 2);

    // Reload after DONE.
    send_frame(2, 0, 1);
    check_status("reload", 1, 0, 0, 2);

    // Bad checksum (6D instead of 6C).
    send_frame(2, 1, 1);
    check_status("badcs", 0, 1, 1, 2);

    // Garbage is dropped without writes.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    settle();
    check("garbage_err", loadError, 1);
    check("garbage_hold", cpuHold, 1);
    fill_payload(3);
    send_frame(3, 0, 0);
    check_status("garbage_ok", 1, 0, 0, 3);

    // Random idle gaps and valid toggling, including during write slots.
    gaps = 1;
    for (int f = 0; f < 4; f++) begin
      int nw;
      nw = $urandom_range(1, 24);
      fill_payload(nw);
      pay[1] = 8'hA5;
      send_frame(nw, 0, 0);
      check_status("bp", 1, 0, 0, 9'(nw));
    end

    // Count byte zero: 256 words, address wraps to 0.
    fill_payload(256);
    send_frame(256, 0, 0);
    check_status("n256", 1, 0, 0, 256);
    check("n256_addr_wrap", imemWrAddr, 0);
    gaps = 0;

    // Reset after three payload bytes, then a full frame.
    fill_payload(3);
    send_byte(8'hA5);
    send_byte(8'h03);
    exp_q.push_back({8'h00, pay[0], pay[1]});
    send_byte(pay[0]); send_byte(pay[1]); send_byte(pay[2]);
    @(negedge clk);
    byteValid = 1'b0;
    check("midrst_q_empty", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wren", imemWrEn, 0);
    check("midrst_addr", imemWrAddr, 0);
    check("midrst_data", imemWrData, 0);
    check("midrst_rdy", byteReady, 1);
    check_status("midrst", 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_payload(3);
    send_frame(3, 0, 0);
    check_status("after_rst", 1, 0, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that fills instruction memory, the write side of the memory the processor fetches from. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes each word into instruction memory at consecutive addresses from 0, verifies an XOR checksum, and holds the processor until a good load completes.

Parameters:
ADDR_W, 8, instruction memory address width (matches 8-bit PC)
INSTR_W, 16, instruction word width; fixed at 2 bytes per word
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
byteIn  input  8  incoming stream byte
byteValid  input  1  byteIn valid this cycle
byteReady  output  1  loader accepts byte this cycle; transfer when byteValid & byteReady
imemWrAddr  output  ADDR_W  instruction memory write address
imemWrData  output  INSTR_W  instruction word to write
imemWrEn  output  1  one-cycle write strobe
cpuHold  output  1  high = processor PC held; low only after successful load
loadDone  output  1  sticky, high after checksum match
loadError  output  1  sticky, high after checksum mismatch
wordsLoaded  output  ADDR_W+1  count of words written in current frame

Behaviour:
- Frame format: SYNC_BYTE, count N (0 encodes 256), 2N payload bytes (high byte first), checksum byte.
- Checksum = XOR of N and all payload bytes; SYNC_BYTE excluded.
- Reset (async, rst_n=0):
  - state=IDLE; imemWrEn=0; imemWrAddr=0; imemWrData=0.
  - cpuHold=1; loadDone=0; loadError=0; wordsLoaded=0; byteReady=1.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR.
- byteReady=1 in every state except WRITE.
- IDLE: byte==SYNC_BYTE -> COUNT. Any other byte is accepted and dropped.
- COUNT: latch N (0 -> 256); running XOR=N; address=0; wordsLoaded=0 -> HI.
- HI: latch high byte, XOR it -> LO.
- LO: latch low byte, XOR it -> WRITE.
- WRITE (one cycle, byteReady=0):
  - imemWrEn=1 with imemWrAddr/imemWrData stable.
  - Next edge: address+1 (wraps 255->0 after the 256th word); wordsLoaded+1.
  - If wordsLoaded reaches N -> CHECK, else -> HI.
- Write latency: imemWrEn asserts the cycle after the LO byte transfer.
- CHECK: compare received byte with running XOR.
  - Equal -> DONE, loadDone=1, cpuHold=0.
  - Not equal -> ERROR, loadError=1, cpuHold stays 1.
- DONE/ERROR:
  - Non-sync bytes are accepted and dropped.
  - SYNC_BYTE -> COUNT; clears loadDone/loadError and sets cpuHold=1 on the same edge (reload).
- SYNC_BYTE appearing inside a frame is payload data, not a restart.
- byteValid=0 in any state: no state change; imemWrEn stays 0 outside WRITE.
- Reset mid-frame: everything returns to reset values; partially written memory is not erased; cpuHold=1.
- Words beyond a short stream are never written. The loader stalls in HI/LO indefinitely and has no timeout.

Decomposition:
- Shared package (loader_pkg): state encoding constants, SYNC_BYTE, INSTR_W, and the COUNT_ZERO_MEANS_256 rule constant.
- One natural sub-module: loader_checksum. It holds the running XOR register with clear/accumulate/compare and is reusable for a future data-memory loader.
- Frame FSM and word assembly stay in imem_loader.

Test Plan:
- Basic load: stream A5 02 4A 1B 0C 33 6C -> writes (0,4A1B) then (1,0C33); loadDone=1, cpuHold=0, wordsLoaded=2.
- Bad checksum: same frame with checksum 6D -> both words written; loadError=1, loadDone=0, cpuHold stays 1.
- Garbage before sync: 00 FF 13 then a valid frame -> garbage dropped, no imemWrEn before the frame; load succeeds.
- N=0, 512 payload bytes -> 256 writes at addresses 0..255, imemWrAddr wraps to 0; wordsLoaded=256; correct checksum gives loadDone.
- Backpressure/idle gaps: byteValid toggled randomly, including during WRITE -> byteReady=0 only in WRITE; no byte lost or duplicated; written data matches the golden model.
- Reset mid-frame after 3 payload bytes, then a full valid frame -> reset values seen immediately (async); second frame loads correctly from address 0.
- Reload: a second valid frame after DONE -> cpuHold returns to 1 on the sync edge, loadDone clears, and drops again after the new checksum passes.
